// File: rtl/mem_stage.sv
// MEM stage: load/store over a req/ack data bus. It stalls the pipeline while an access is outstanding.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mem_wd_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_data_sel_i,
  input  logic [4:0]  wr_i,
  input  logic [1:0]  wd_sel_i,
  input  logic        regfile_we_i,
  input  logic [31:0] return_pc_i,
  input  logic [31:0] current_pc_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_o,
  output logic [31:0] wd_o,
  output logic [4:0]  wr_o,
  output logic        regfile_we_o,
  output logic [31:0] current_pc_o,
  output logic        misalign_o,
  output logic        mem_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op;
  logic        req;
  logic        timeout;
  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;

  assign off    = alu_result_i[1:0];
  assign mem_op = mem_we_i | (regfile_we_i & (wd_sel_i == 2'b01));

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout = (state_q == StWait) && !bus_ack_i &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter is zero outside WAIT, so it starts from zero on every entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StWait) cnt_d = cnt_q + CntW'(1);
    err_d = timeout;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err_o = err_q & (state_q == StDone);
`else
  assign timeout   = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          req     = 1'b1;
          state_d = bus_ack_i ? StDone : StWait;
        end
      end
      StWait: begin
        req = 1'b1;
        if (bus_ack_i || timeout) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The EX/MEM register still holds the op while reset is applied, so gate the request directly.
  assign bus_req_o = req & ~rst_i;
  assign stall_o   = bus_req_o & (state_q != StDone);

  always_comb begin
    rdata_d = rdata_q;
    if (bus_req_o && bus_ack_i) rdata_d = bus_rdata_i;
    else if (timeout)           rdata_d = 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus_wdata_o = mem_wd_i;
    st_be       = 4'b1111;
    unique case (mem_data_sel_i)
      2'b00: begin
        bus_wdata_o = mem_wd_i;
        st_be       = 4'b1111;
      end
      2'b01: begin
        bus_wdata_o = {2{mem_wd_i[15:0]}};
        st_be       = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        bus_wdata_o = {4{mem_wd_i[7:0]}};
        st_be       = 4'b0001 << off;
      end
    endcase
  end

  assign bus_addr_o = {alu_result_i[31:2], 2'b00};
  assign bus_we_o   = bus_req_o & mem_we_i;
  assign bus_be_o   = bus_req_o ? (mem_we_i ? st_be : 4'b1111) : 4'b0000;
  assign misalign_o = bus_req_o & (((mem_data_sel_i == 2'b01) & off[0]) |
                                   ((mem_data_sel_i == 2'b00) & (off != 2'b00)));

  assign ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_byte = rdata_q[7:0];
    unique case (off)
      2'b00: ld_byte = rdata_q[7:0];
      2'b01: ld_byte = rdata_q[15:8];
      2'b10: ld_byte = rdata_q[23:16];
      2'b11: ld_byte = rdata_q[31:24];
      default: ld_byte = rdata_q[7:0];
    endcase
  end

  always_comb begin
    ld_data = rdata_q;
    unique case (mem_data_sel_i)
      2'b00: ld_data = rdata_q;
      2'b01: ld_data = {{16{ld_half[15]}}, ld_half};
      2'b10: ld_data = {{24{ld_byte[7]}}, ld_byte};
      2'b11: ld_data = {24'h0, ld_byte};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    wd_o = alu_result_i;
    unique case (wd_sel_i)
      2'b01:   wd_o = ld_data;
      2'b10:   wd_o = return_pc_i;
      default: wd_o = alu_result_i;
    endcase
  end

  assign wr_o         = wr_i;
  assign regfile_we_o = regfile_we_i & ~stall_o;
  assign current_pc_o = current_pc_i;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues expected bus and write-back records,
// and the monitor pops and compares them as the DUT presents them.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned ToCycles = 4;
`else
  localparam int unsigned ToCycles = 255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] alu_result_i = '0, mem_wd_i = '0, return_pc_i = '0, current_pc_i = '0;
  logic        mem_we_i = 1'b0, regfile_we_i = 1'b0;
  logic [1:0]  mem_data_sel_i = '0, wd_sel_i = '0;
  logic [4:0]  wr_i = '0;
  logic        bus_req_o, bus_we_o, bus_ack_i = 1'b0;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i = '0;
  logic [3:0]  bus_be_o;
  logic        stall_o, regfile_we_o, misalign_o, mem_err_o;
  logic [31:0] wd_o, current_pc_o;
  logic [4:0]  wr_o;

  mem_stage #(.TIMEOUT_CYCLES(ToCycles)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .alu_result_i(alu_result_i), .mem_wd_i(mem_wd_i),
    .mem_we_i(mem_we_i), .mem_data_sel_i(mem_data_sel_i), .wr_i(wr_i), .wd_sel_i(wd_sel_i),
    .regfile_we_i(regfile_we_i), .return_pc_i(return_pc_i), .current_pc_i(current_pc_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_o(stall_o), .wd_o(wd_o), .wr_o(wr_o), .regfile_we_o(regfile_we_o),
    .current_pc_o(current_pc_o), .misalign_o(misalign_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis;
  } bus_t;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } wb_t;

  bus_t exp_bus[$];
  wb_t  exp_wb[$];
  int   total = 0;
  int   bad = 0;
  int   ack_dly = 0;
  logic [31:0] plan_rdata = '0;
  int   op_id = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Bus responder: acks after ack_dly request cycles.
  initial begin
    int req_cnt = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (bus_req_o) begin
        bus_ack_i   = (req_cnt == ack_dly);
        bus_rdata_i = bus_ack_i ? plan_rdata : 32'hDEAD_BEEF;
        req_cnt++;
      end else begin
        bus_ack_i = 1'b0;
        req_cnt   = 0;
      end
    end
  end

  // Monitor
  initial begin
    bus_t b;
    wb_t  w;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (stall_o) chk("we_in_stall", {63'h0, regfile_we_o}, 64'h0);
        if (bus_req_o && bus_ack_i) begin
          if (exp_bus.size() == 0) chk("bus_unexpected", 64'h1, 64'h0);
          else begin
            b = exp_bus.pop_front();
            chk("bus_xfer", {63'h0, bus_we_o}, {63'h0, b.we});
            chk("bus_addr", {32'h0, bus_addr_o}, {32'h0, b.addr});
            chk("bus_be", {60'h0, bus_be_o}, {60'h0, b.be});
            chk("bus_wdata", {32'h0, bus_wdata_o}, {32'h0, b.wdata});
            chk("misalign", {63'h0, misalign_o}, {63'h0, b.mis});
          end
        end
        if (!stall_o && regfile_we_o) begin
          if (exp_wb.size() == 0) chk("wb_unexpected", 64'h1, 64'h0);
          else begin
            w = exp_wb.pop_front();
            chk("wb_wr", {59'h0, wr_o}, {59'h0, w.wr});
            chk("wb_wd", {32'h0, wd_o}, {32'h0, w.wd});
          end
        end
      end
    end
  end

  task automatic drive_idle();
    mem_we_i = 1'b0; regfile_we_i = 1'b0; wd_sel_i = 2'b00; mem_data_sel_i = 2'b00;
    alu_result_i = '0; mem_wd_i = '0;
  endtask

  task automatic run_op(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [1:0] wdsel, input logic rfwe,
                        input int dly, input logic [31:0] rd, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_wd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_mis);
    int   n;
    logic mop;
    logic [31:0] pc;
    op_id++;
    pc = 32'h1000 + op_id * 4;
    @(posedge clk_i);
    #1;
    mem_we_i = we; mem_data_sel_i = sel; alu_result_i = addr; mem_wd_i = wdat;
    wd_sel_i = wdsel; regfile_we_i = rfwe; wr_i = op_id[4:0]; current_pc_i = pc;
    return_pc_i = 32'h0000_0444;
    ack_dly = dly; plan_rdata = rd;
    mop = we | (rfwe & (wdsel == 2'b01));
    if (mop && !exp_err) exp_bus.push_back({we, addr & 32'hFFFF_FFFC, exp_be, exp_wdata, exp_mis});
    if (rfwe) exp_wb.push_back({op_id[4:0], exp_wd});
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!stall_o) break;
      n++;
      if (n > 400) begin
        chk("stall_bound", 64'h1, 64'h0);
        break;
      end
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("req_done", {63'h0, bus_req_o}, 64'h0);
    chk("mem_err", {63'h0, mem_err_o}, {63'h0, exp_err});
    chk("pc_pass", {32'h0, current_pc_o}, {32'h0, pc});
    @(posedge clk_i);
    #1;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    #3;
    chk("rst_req", {63'h0, bus_req_o}, 64'h0);
    chk("rst_we", {63'h0, bus_we_o}, 64'h0);
    chk("rst_be", {60'h0, bus_be_o}, 64'h0);
    chk("rst_stall", {63'h0, stall_o}, 64'h0);
    chk("rst_err", {63'h0, mem_err_o}, 64'h0);
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_i = 1'b0;

    //     we    sel    addr          wdat          wdsel  rfwe dly rdata        lat err exp_wd        be       wdata         mis
    run_op(1'b0, 2'b00, 32'h0000_0100, 32'h0,        2'b01, 1'b1, 0, 32'h8765_4321, 1, 0, 32'h8765_4321, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b10, 32'h0000_0103, 32'h0,        2'b01, 1'b1, 0, 32'h8012_3456, 1, 0, 32'hFFFF_FF80, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b11, 32'h0000_0103, 32'h0,        2'b01, 1'b1, 0, 32'h8012_3456, 1, 0, 32'h0000_0080, 4'b1111, 32'h0,        0);
    run_op(1'b1, 2'b01, 32'h0000_0202, 32'h0000_ABCD, 2'b00, 1'b0, 0, 32'h0,        1, 0, 32'h0,        4'b1100, 32'hABCD_ABCD, 0);
    run_op(1'b1, 2'b00, 32'h0000_0300, 32'h1234_5678, 2'b00, 1'b0, 3, 32'h0,        4, 0, 32'h0,        4'b1111, 32'h1234_5678, 0);
    run_op(1'b0, 2'b01, 32'h0000_0106, 32'h0,        2'b01, 1'b1, 1, 32'h8001_7FFF, 2, 0, 32'hFFFF_8001, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b01, 32'h0000_0101, 32'h0,        2'b01, 1'b1, 0, 32'h1234_5678, 1, 0, 32'h0000_5678, 4'b1111, 32'h0,        1);
    run_op(1'b0, 2'b00, 32'h0000_010A, 32'h0,        2'b01, 1'b1, 0, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 4'b1111, 32'h0,        1);
    run_op(1'b1, 2'b10, 32'h0000_0401, 32'h0000_00A5, 2'b00, 1'b0, 0, 32'h0,        1, 0, 32'h0,        4'b0010, 32'hA5A5_A5A5, 0);
    run_op(1'b0, 2'b11, 32'h0000_0102, 32'h0,        2'b01, 1'b1, 2, 32'h00AB_0000, 3, 0, 32'h0000_00AB, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b00, 32'h0000_1234, 32'h0,        2'b00, 1'b1, 0, 32'h0,        0, 0, 32'h0000_1234, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b00, 32'h0000_0777, 32'h0,        2'b10, 1'b1, 0, 32'h0,        0, 0, 32'h0000_0444, 4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b00, 32'h0000_0055, 32'h0,        2'b11, 1'b1, 0, 32'h0,        0, 0, 32'h0000_0055, 4'b1111, 32'h0,        0);

    // Reset during WAIT with the op still held on the inputs.
    @(posedge clk_i);
    #1;
    alu_result_i = 32'h0000_0600; wd_sel_i = 2'b01; regfile_we_i = 1'b1; ack_dly = 1000;
    @(negedge clk_i);
    chk("abort_stall_idle", {63'h0, stall_o}, 64'h1);
    @(negedge clk_i);
    chk("abort_stall_wait", {63'h0, stall_o}, 64'h1);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("abort_req", {63'h0, bus_req_o}, 64'h0);
    chk("abort_stall", {63'h0, stall_o}, 64'h0);
    @(posedge clk_i);
    #1 drive_idle();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    run_op(1'b0, 2'b00, 32'h0000_0700, 32'h0,        2'b01, 1'b1, 0, 32'h5A5A_1234, 1, 0, 32'h5A5A_1234, 4'b1111, 32'h0,        0);

`ifdef MEM_TIMEOUT_EN
    run_op(1'b0, 2'b00, 32'h0000_0500, 32'h0,        2'b01, 1'b1, 1000, 32'h0,     5, 1, 32'h0,        4'b1111, 32'h0,        0);
    run_op(1'b0, 2'b00, 32'h0000_0504, 32'h0,        2'b01, 1'b1, 0, 32'h1111_2222, 1, 0, 32'h1111_2222, 4'b1111, 32'h0,        0);
`endif

    repeat (3) @(posedge clk_i);
    chk("bus_q_empty", 64'(exp_bus.size()), 64'h0);
    chk("wb_q_empty", 64'(exp_wb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
